// File: rtl/beta_pkg.sv
// Shared types for the beta writeback stage: the buffered execute-result entry
// and the depth of the writeback FIFO.
package beta_pkg;

  localparam int WB_FIFO_DEPTH = 2;
  localparam int WB_DATA_W     = 32;

  typedef struct packed {
    logic [WB_DATA_W-1:0] result;
    logic [4:0]           rd;
    logic                 we;
    logic [WB_DATA_W-1:0] next_pc;
    logic                 redirect;
    logic                 trap;
  } wb_entry_t;

endpackage

// File: rtl/beta_wb_fifo.sv
// Two-entry FIFO of completed execute results. Pushes while full and pops while
// empty are ignored; all entries are visible for forwarding.
module beta_wb_fifo
  import beta_pkg::*;
(
  input  logic                                 clk_i,
  input  logic                                 rstn_i,
  input  logic                                 push_i,
  input  wb_entry_t                            push_entry_i,
  input  logic                                 pop_i,
  output wb_entry_t                            head_o,
  output wb_entry_t [WB_FIFO_DEPTH-1:0]        entries_o,
  output logic      [WB_FIFO_DEPTH-1:0]        valid_o,
  output logic                                 head_idx_o,
  output logic                                 full_o,
  output logic                                 empty_o
);

  wb_entry_t [WB_FIFO_DEPTH-1:0] r_mem;
  logic                          r_wr_ptr;
  logic                          r_rd_ptr;
  logic [1:0]                    r_count;

  logic w_push;
  logic w_pop;

  assign full_o  = (r_count == 2'd2);
  assign empty_o = (r_count == 2'd0);
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_mem    <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= push_entry_i;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // With one entry only the head slot is live; with two, both are.
  for (genvar gi = 0; gi < WB_FIFO_DEPTH; gi++) begin : g_valid
    assign valid_o[gi] = full_o | ((r_count == 2'd1) & (r_rd_ptr == 1'(gi)));
  end

  assign entries_o  = r_mem;
  assign head_o     = r_mem[r_rd_ptr];
  assign head_idx_o = r_rd_ptr;

endmodule

// File: rtl/beta_wb_stage.sv
// Writeback/commit stage: buffers execute results, drains them to the register
// file, tracks the architectural PC, redirects fetch and counts retirements.
module beta_wb_stage
  import beta_pkg::*;
#(
  parameter int                  DataWidth = 32,
  parameter logic [DataWidth-1:0] ResetPc  = 32'h0000_0000
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 wb_valid_i,
  input  logic [DataWidth-1:0] wb_result_i,
  input  logic [4:0]           wb_rd_addr_i,
  input  logic                 wb_reg_wr_en_i,
  input  logic [DataWidth-1:0] wb_next_pc_i,
  input  logic                 wb_branch_taken_i,
  input  logic                 wb_trap_taken_i,
  output logic                 wb_stage_busy_o,
  output logic                 rf_wr_en_o,
  output logic [4:0]           rf_wr_addr_o,
  output logic [DataWidth-1:0] rf_wr_data_o,
  input  logic                 rf_wr_ready_i,
  output logic [DataWidth-1:0] wb_pc_o,
  output logic                 wb_redirect_o,
  input  logic [4:0]           dec_rs1_addr_i,
  input  logic [4:0]           dec_rs2_addr_i,
  output logic                 wb_fwd_rs1_hit_o,
  output logic                 wb_fwd_rs2_hit_o,
  output logic [DataWidth-1:0] wb_fwd_rs1_data_o,
  output logic [DataWidth-1:0] wb_fwd_rs2_data_o,
  output logic [63:0]          wb_instret_o
);

  wb_entry_t                     w_push_entry;
  wb_entry_t                     w_head;
  wb_entry_t [WB_FIFO_DEPTH-1:0] w_entries;
  logic      [WB_FIFO_DEPTH-1:0] w_valid;
  logic                          w_head_idx;
  logic                          w_full;
  logic                          w_empty;
  logic                          w_accept;
  logic                          w_retire;

  logic [DataWidth-1:0] r_pc;
  logic                 r_redirect;
  logic [63:0]          r_instret;

  // Trapped instructions and writes to x0 never reach the register file.
  always_comb begin
    w_push_entry          = '0;
    w_push_entry.result   = wb_result_i;
    w_push_entry.rd       = wb_rd_addr_i;
    w_push_entry.we       = wb_reg_wr_en_i & ~wb_trap_taken_i & (wb_rd_addr_i != 5'd0);
    w_push_entry.next_pc  = wb_next_pc_i;
    w_push_entry.redirect = wb_branch_taken_i | wb_trap_taken_i;
    w_push_entry.trap     = wb_trap_taken_i;
  end

  assign w_accept = wb_valid_i & ~w_full;
  assign w_retire = ~w_empty & (~w_head.we | rf_wr_ready_i);

  beta_wb_fifo u_fifo (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .push_i       (w_accept),
    .push_entry_i (w_push_entry),
    .pop_i        (w_retire),
    .head_o       (w_head),
    .entries_o    (w_entries),
    .valid_o      (w_valid),
    .head_idx_o   (w_head_idx),
    .full_o       (w_full),
    .empty_o      (w_empty)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_pc       <= ResetPc;
      r_redirect <= 1'b0;
      r_instret  <= 64'd0;
    end else begin
      r_redirect <= w_retire & w_head.redirect;
      if (w_retire) begin
        r_pc <= w_head.next_pc;
        if (!w_head.trap) begin
          r_instret <= r_instret + 64'd1;
        end
      end
    end
  end

  assign wb_stage_busy_o = w_full;
  assign rf_wr_en_o      = ~w_empty & w_head.we;
  assign rf_wr_addr_o    = w_empty ? 5'd0 : w_head.rd;
  assign rf_wr_data_o    = w_empty ? '0 : w_head.result;
  assign wb_pc_o         = r_pc;
  assign wb_redirect_o   = r_redirect;
  assign wb_instret_o    = r_instret;

  logic [1:0][4:0]           w_src;
  logic [1:0]                w_hit;
  logic [1:0][DataWidth-1:0] w_fwd;

  assign w_src = {dec_rs2_addr_i, dec_rs1_addr_i};

  // The head is checked first so the younger entry, when present, overrides it.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    always_comb begin
      w_hit[gi] = 1'b0;
      w_fwd[gi] = '0;
      if (w_src[gi] != 5'd0) begin
        if (!w_empty && w_head.we && (w_head.rd == w_src[gi])) begin
          w_hit[gi] = 1'b1;
          w_fwd[gi] = w_head.result;
        end
        if (w_valid[~w_head_idx] && w_entries[~w_head_idx].we &&
            (w_entries[~w_head_idx].rd == w_src[gi])) begin
          w_hit[gi] = 1'b1;
          w_fwd[gi] = w_entries[~w_head_idx].result;
        end
      end
    end
  end

  assign wb_fwd_rs1_hit_o  = w_hit[0];
  assign wb_fwd_rs2_hit_o  = w_hit[1];
  assign wb_fwd_rs1_data_o = w_fwd[0];
  assign wb_fwd_rs2_data_o = w_fwd[1];

endmodule

// File: tb/tb_beta_wb_stage.sv
// Directed bench for beta_wb_stage: each step drives inputs 1ns after a rising
// edge and checks outputs at that same settled point.
module tb_beta_wb_stage;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        wb_valid_i;
  logic [31:0] wb_result_i;
  logic [4:0]  wb_rd_addr_i;
  logic        wb_reg_wr_en_i;
  logic [31:0] wb_next_pc_i;
  logic        wb_branch_taken_i;
  logic        wb_trap_taken_i;
  logic        wb_stage_busy_o;
  logic        rf_wr_en_o;
  logic [4:0]  rf_wr_addr_o;
  logic [31:0] rf_wr_data_o;
  logic        rf_wr_ready_i;
  logic [31:0] wb_pc_o;
  logic        wb_redirect_o;
  logic [4:0]  dec_rs1_addr_i;
  logic [4:0]  dec_rs2_addr_i;
  logic        wb_fwd_rs1_hit_o;
  logic        wb_fwd_rs2_hit_o;
  logic [31:0] wb_fwd_rs1_data_o;
  logic [31:0] wb_fwd_rs2_data_o;
  logic [63:0] wb_instret_o;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk_i = ~clk_i;

  beta_wb_stage #(.DataWidth(32), .ResetPc(32'h0000_0000)) dut (
    .clk_i             (clk_i),
    .rstn_i            (rstn_i),
    .wb_valid_i        (wb_valid_i),
    .wb_result_i       (wb_result_i),
    .wb_rd_addr_i      (wb_rd_addr_i),
    .wb_reg_wr_en_i    (wb_reg_wr_en_i),
    .wb_next_pc_i      (wb_next_pc_i),
    .wb_branch_taken_i (wb_branch_taken_i),
    .wb_trap_taken_i   (wb_trap_taken_i),
    .wb_stage_busy_o   (wb_stage_busy_o),
    .rf_wr_en_o        (rf_wr_en_o),
    .rf_wr_addr_o      (rf_wr_addr_o),
    .rf_wr_data_o      (rf_wr_data_o),
    .rf_wr_ready_i     (rf_wr_ready_i),
    .wb_pc_o           (wb_pc_o),
    .wb_redirect_o     (wb_redirect_o),
    .dec_rs1_addr_i    (dec_rs1_addr_i),
    .dec_rs2_addr_i    (dec_rs2_addr_i),
    .wb_fwd_rs1_hit_o  (wb_fwd_rs1_hit_o),
    .wb_fwd_rs2_hit_o  (wb_fwd_rs2_hit_o),
    .wb_fwd_rs1_data_o (wb_fwd_rs1_data_o),
    .wb_fwd_rs2_data_o (wb_fwd_rs2_data_o),
    .wb_instret_o      (wb_instret_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Execute must never present a result while the stage reports busy.
  always @(posedge clk_i) begin
    if (rstn_i && wb_valid_i && wb_stage_busy_o) begin
      n_total++;
      $error("FAIL protocol valid_while_busy observed=1 expected=0");
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Presents one instruction for a single edge, then drops valid.
  task automatic send(input logic [4:0] rd, input logic [31:0] res, input logic we,
                      input logic [31:0] npc, input logic br, input logic trap);
    wb_valid_i        = 1'b1;
    wb_rd_addr_i      = rd;
    wb_result_i       = res;
    wb_reg_wr_en_i    = we;
    wb_next_pc_i      = npc;
    wb_branch_taken_i = br;
    wb_trap_taken_i   = trap;
    tick();
    wb_valid_i        = 1'b0;
    wb_branch_taken_i = 1'b0;
    wb_trap_taken_i   = 1'b0;
  endtask

  initial begin
    rstn_i = 1'b0; wb_valid_i = 1'b0; wb_result_i = '0; wb_rd_addr_i = '0;
    wb_reg_wr_en_i = 1'b0; wb_next_pc_i = '0; wb_branch_taken_i = 1'b0;
    wb_trap_taken_i = 1'b0; rf_wr_ready_i = 1'b1;
    dec_rs1_addr_i = '0; dec_rs2_addr_i = '0;

    // Reset state
    tick(); tick();
    chk("rst_pc", 64'(wb_pc_o), 64'h0);
    chk("rst_en", 64'(rf_wr_en_o), 64'h0);
    chk("rst_busy", 64'(wb_stage_busy_o), 64'h0);
    chk("rst_redirect", 64'(wb_redirect_o), 64'h0);
    chk("rst_instret", wb_instret_o, 64'h0);
    chk("rst_addr_data", {27'h0, rf_wr_addr_o, rf_wr_data_o}, 64'h0);
    rstn_i = 1'b1;
    tick();
    $display("step reset done");

    // Single ADD x5 = 0x1234
    send(5'd5, 32'h1234, 1'b1, 32'h4, 1'b0, 1'b0);
    chk("add_en", 64'(rf_wr_en_o), 64'h1);
    chk("add_addr", 64'(rf_wr_addr_o), 64'h5);
    chk("add_data", 64'(rf_wr_data_o), 64'h1234);
    tick();
    chk("add_pc", 64'(wb_pc_o), 64'h4);
    chk("add_instret", wb_instret_o, 64'h1);
    chk("add_redirect", 64'(wb_redirect_o), 64'h0);
    chk("add_en_after", 64'(rf_wr_en_o), 64'h0);
    $display("step add x5 retired");

    // Backpressure: ready low, fill the FIFO, then drain
    rf_wr_ready_i = 1'b0;
    send(5'd1, 32'h11, 1'b1, 32'h8, 1'b0, 1'b0);
    chk("bp_busy1", 64'(wb_stage_busy_o), 64'h0);
    send(5'd2, 32'h22, 1'b1, 32'hC, 1'b0, 1'b0);
    chk("bp_busy2", 64'(wb_stage_busy_o), 64'h1);
    tick();
    chk("bp_hold_en", 64'(rf_wr_en_o), 64'h1);
    chk("bp_hold_addr", 64'(rf_wr_addr_o), 64'h1);
    chk("bp_hold_data", 64'(rf_wr_data_o), 64'h11);
    chk("bp_hold_busy", 64'(wb_stage_busy_o), 64'h1);
    rf_wr_ready_i = 1'b1;
    tick();
    chk("bp_busy_drop", 64'(wb_stage_busy_o), 64'h0);
    chk("bp_pc1", 64'(wb_pc_o), 64'h8);
    chk("bp_addr2", 64'(rf_wr_addr_o), 64'h2);
    chk("bp_data2", 64'(rf_wr_data_o), 64'h22);
    send(5'd3, 32'h33, 1'b1, 32'h10, 1'b0, 1'b0);
    chk("bp_pc2", 64'(wb_pc_o), 64'hC);
    chk("bp_addr3", 64'(rf_wr_addr_o), 64'h3);
    chk("bp_data3", 64'(rf_wr_data_o), 64'h33);
    chk("bp_busy3", 64'(wb_stage_busy_o), 64'h0);
    tick();
    chk("bp_pc3", 64'(wb_pc_o), 64'h10);
    chk("bp_instret", wb_instret_o, 64'h4);
    chk("bp_empty_en", 64'(rf_wr_en_o), 64'h0);
    $display("step backpressure drained");

    // Forwarding: two pending writes to x7, the younger wins
    rf_wr_ready_i = 1'b0;
    send(5'd7, 32'hA, 1'b1, 32'h14, 1'b0, 1'b0);
    send(5'd7, 32'hB, 1'b1, 32'h18, 1'b0, 1'b0);
    dec_rs1_addr_i = 5'd7; dec_rs2_addr_i = 5'd3;
    #1;
    chk("fwd_rs1_hit", 64'(wb_fwd_rs1_hit_o), 64'h1);
    chk("fwd_rs1_data", 64'(wb_fwd_rs1_data_o), 64'hB);
    chk("fwd_rs2_miss", 64'(wb_fwd_rs2_hit_o), 64'h0);
    rf_wr_ready_i = 1'b1;
    tick();
    chk("fwd_rs1_hit_one", 64'(wb_fwd_rs1_hit_o), 64'h1);
    chk("fwd_rs1_data_one", 64'(wb_fwd_rs1_data_o), 64'hB);
    tick();
    chk("fwd_rs1_empty", 64'(wb_fwd_rs1_hit_o), 64'h0);
    chk("fwd_pc", 64'(wb_pc_o), 64'h18);
    chk("fwd_instret", wb_instret_o, 64'h6);
    dec_rs2_addr_i = 5'd0;
    send(5'd0, 32'h55, 1'b1, 32'h1C, 1'b0, 1'b0);
    chk("x0_en", 64'(rf_wr_en_o), 64'h0);
    chk("x0_rs2_hit", 64'(wb_fwd_rs2_hit_o), 64'h0);
    tick();
    chk("x0_pc", 64'(wb_pc_o), 64'h1C);
    chk("x0_instret", wb_instret_o, 64'h7);
    $display("step forwarding and x0 done");

    // Trap: no write, redirect pulse, instret unchanged
    send(5'd9, 32'h99, 1'b1, 32'h100, 1'b0, 1'b1);
    chk("trap_en", 64'(rf_wr_en_o), 64'h0);
    tick();
    chk("trap_pc", 64'(wb_pc_o), 64'h100);
    chk("trap_redirect", 64'(wb_redirect_o), 64'h1);
    chk("trap_instret", wb_instret_o, 64'h7);
    tick();
    chk("trap_redirect_end", 64'(wb_redirect_o), 64'h0);
    $display("step trap done");

    // Back-to-back taken branches give consecutive redirect pulses
    send(5'd0, 32'h0, 1'b0, 32'h200, 1'b1, 1'b0);
    send(5'd0, 32'h0, 1'b0, 32'h300, 1'b1, 1'b0);
    chk("br1_pc", 64'(wb_pc_o), 64'h200);
    chk("br1_redirect", 64'(wb_redirect_o), 64'h1);
    tick();
    chk("br2_pc", 64'(wb_pc_o), 64'h300);
    chk("br2_redirect", 64'(wb_redirect_o), 64'h1);
    chk("br_instret", wb_instret_o, 64'h9);
    tick();
    chk("br_redirect_end", 64'(wb_redirect_o), 64'h0);
    $display("step branches done");

    // instret wrap
    force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.r_instret;
    send(5'd4, 32'h44, 1'b1, 32'h304, 1'b0, 1'b0);
    tick();
    chk("wrap_instret", wb_instret_o, 64'h0);
    $display("step instret wrap done");

    // Asynchronous reset with two entries pending
    rf_wr_ready_i = 1'b0;
    send(5'd10, 32'hAA, 1'b1, 32'h400, 1'b0, 1'b0);
    send(5'd11, 32'hBB, 1'b1, 32'h404, 1'b0, 1'b0);
    chk("mr_busy_pre", 64'(wb_stage_busy_o), 64'h1);
    #2;
    rstn_i = 1'b0;
    #1;
    chk("mr_pc", 64'(wb_pc_o), 64'h0);
    chk("mr_en", 64'(rf_wr_en_o), 64'h0);
    chk("mr_busy", 64'(wb_stage_busy_o), 64'h0);
    chk("mr_instret", wb_instret_o, 64'h0);
    chk("mr_addr", 64'(rf_wr_addr_o), 64'h0);
    rf_wr_ready_i = 1'b1;
    tick();
    rstn_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mr_no_write", 64'(rf_wr_en_o), 64'h0);
    end
    chk("mr_pc_after", 64'(wb_pc_o), 64'h0);
    $display("step mid-drain reset done");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
